seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Downstream consumer of the single-cycle RISC-V core's result bus.
- Captures a 32-bit value on a load strobe and shows it as 8 hex digits on the board's multiplexed 7-segment display.
- Time-multiplexes the digits with a refresh prescaler and digit counter, and drives the active-low anode and cathode pins (Anode_Activate, LED_out) that the top level brings out.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit); legal range >= 1
NUM_DIGITS, 8, number of digits scanned; fixed at 8 for this board, width of Anode_Activate
BLANK_LZ, 1, 1 = blank leading zero digits, 0 = show all digits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
value_in  in  32  result word from the core
load  in  1  capture strobe: value_in is registered on an edge where load=1
Anode_Activate  out  8  active-low digit enables; bit k = digit k, digit 0 = least significant nibble
LED_out  out  7  active-low segments, {a,b,c,d,e,f,g} = LED_out[6:0]
disp_zero  out  1  1 when the captured value is 0, registered

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state changes occur on the rising edge of clk.
- Reset values:
  - shown_value = 0; prescaler = 0; digit index = NUM_DIGITS-1.
  - Anode_Activate = 8'hFF (all off); LED_out = 7'h7F (all off); disp_zero = 1.
- Reset mid-operation: on the next edge all state returns to the reset values, regardless of load or tick.
- Capture:
  - On an edge with load=1: shown_value <= value_in, and disp_zero <= (value_in == 0) on the same edge.
  - The load pulse width is irrelevant; each edge with load=1 recaptures.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1). With REFRESH_DIV=1, tick is asserted every cycle.
- Scan, on an edge with tick=1:
  - idx_n = (idx == NUM_DIGITS-1) ? 0 : idx+1, and idx <= idx_n.
  - Anode_Activate <= ~(1 << idx_n), so exactly one bit is low.
  - LED_out <= blank ? 7'h7F : SEG_LUT[shown_value[4*idx_n +: 4]].
  - Outputs hold between ticks.
  - The first tick after reset selects digit 0, i.e. after REFRESH_DIV cycles.
- Load and tick on the same edge: the tick uses the pre-load shown_value. The new value appears from the following tick onward; there is no mixed-value digit within a slot.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k > 0 is blanked iff shown_value[31:4k] == 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The anode of a blanked digit is still driven low; only the segments are off, which keeps per-digit duty constant.
- Latency:
  - load -> disp_zero: 1 cycle.
  - load -> new pattern on a given digit: at most NUM_DIGITS*REFRESH_DIV + 1 cycles.
- Outputs are fully registered, with no combinational path from inputs to pins.

Decomposition:
- Shared package seg7_pkg:
  - SEG_LUT, 16 x 7-bit active-low, index 0..F = 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex).
  - SEG_BLANK = 7'h7F; ANODE_OFF = 8'hFF.
- One sub-module: hex_to_seg7. Combinational 4-bit nibble to 7-bit pattern via SEG_LUT; instantiated once on the muxed nibble.

Test Plan:
1. REFRESH_DIV=4; rst held 2 cycles, then load=1 with value_in=32'h1234ABCD for 1 cycle.
   - disp_zero=0 after 1 cycle.
   - Over the next 32 cycles the anodes step FE,FD,FB,F7,EF,DF,BF,7F, changing every 4 cycles.
   - LED_out per slot = 42,31,60,08,4C,06,12,4F.
2. BLANK_LZ=1; load 32'h000000A5.
   - Digit0 LED_out=24, digit1=08, digits 2..7 LED_out=7F with their anode bit low.
   - With BLANK_LZ=0, digits 2..7 show 01.
3. Load 32'h0.
   - disp_zero=1.
   - Digit0 shows 01; all other digits are blanked.
4. Assert load=1 with 32'hFFFFFFFF exactly on a tick edge while digit 2 is being entered with old value 32'h1234ABCD.
   - Digit 2 shows 60 (old value).
   - Digit 3 onward shows 38.
5. Assert rst for 1 cycle mid-scan while digit 5 is active.
   - Next edge: Anode_Activate=FF, LED_out=7F, disp_zero=1.
   - After 4 cycles digit 0 is active and showing 01.
6. REFRESH_DIV=1.
   - Anodes rotate every cycle and wrap from 7F to FE with no dead cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low segment
// patterns and the all-off levels for segments and anodes.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // {a,b,c,d,e,f,g}, active low, indexed by nibble value 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern, purely combinational.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Captures a 32-bit result word and scans it as hex digits across a
// multiplexed, active-low 7-segment display. All pins are registered.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value_in,
  input  logic                  load,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  disp_zero
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [31:0]   shown_value;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_n;
  logic          tick, blank;
  logic [3:0]    nib;
  logic [6:0]    seg;

  assign tick  = (presc == PW'(REFRESH_DIV - 1));
  assign idx_n = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  assign nib   = shown_value[4*idx_n +: 4];

  // Digit 0 is never blanked so a zero value still shows one "0".
  assign blank = (BLANK_LZ != 0) && (idx_n != '0) &&
                 ((shown_value >> {idx_n, 2'b00}) == 32'h0);

  hex_to_seg7 u_hex (
    .nib (nib),
    .seg (seg)
  );

  // The scan reads shown_value before a same-edge load lands, so a slot
  // never mixes old and new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown_value    <= '0;
      presc          <= '0;
      idx            <= IW'(NUM_DIGITS - 1);
      Anode_Activate <= ANODE_OFF;
      LED_out        <= SEG_BLANK;
      disp_zero      <= 1'b1;
    end else begin
      if (load) begin
        shown_value <= value_in;
        disp_zero   <= (value_in == 32'h0);
      end
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx            <= idx_n;
        Anode_Activate <= ~(NUM_DIGITS'(1) << idx_n);
        LED_out        <= blank ? SEG_BLANK : seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: expected digit slots are queued when a value is loaded and
// popped whenever a scanning display enters a new digit.
module tb_seg7_scan_display;

  typedef struct {
    logic [7:0] an;
    logic [6:0] led;
  } exp_t;

  localparam logic [6:0] LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        rst, load;
  logic [31:0] value_in;
  logic [7:0]  an4, an4n, an1;
  logic [6:0]  led4, led4n, led1;
  logic        dz4, dz4n, dz1;

  int n_chk = 0, n_err = 0, cyc = 0;
  int last4 = 0;
  logic [7:0] prev4 = 8'hFF, prev4n = 8'hFF, prev1 = 8'hFF;
  exp_t q4[$], q4n[$];

  always #5 clk = ~clk;

  seg7_scan_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_LZ(1)) u4 (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .Anode_Activate(an4), .LED_out(led4), .disp_zero(dz4));

  seg7_scan_display #(.REFRESH_DIV(4), .NUM_DIGITS(8), .BLANK_LZ(0)) u4n (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .Anode_Activate(an4n), .LED_out(led4n), .disp_zero(dz4n));

  seg7_scan_display #(.REFRESH_DIV(1), .NUM_DIGITS(8), .BLANK_LZ(1)) u1 (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .Anode_Activate(an1), .LED_out(led1), .disp_zero(dz1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_led(input logic [31:0] v, input int k, input bit blz);
    logic [31:0] up;
    up = v >> (4 * k);
    if (blz && k != 0 && up == 32'h0) return 7'h7F;
    return LUT[up[3:0]];
  endfunction

  task automatic push_scan(input logic [31:0] v, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      q4.push_back('{an: 8'(~(8'h01 << k)), led: exp_led(v, k, 1'b1)});
      q4n.push_back('{an: 8'(~(8'h01 << k)), led: exp_led(v, k, 1'b0)});
    end
  endtask

  // One reset edge, then a one-cycle load; leaves us at posedge+1 after the load edge.
  task automatic start(input logic [31:0] v);
    rst = 1'b1; load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b1; value_in = v;
    @(posedge clk); #1;
    load = 1'b0;
    chk("disp_zero", {31'h0, dz4}, {31'h0, (v == 32'h0)});
    chk("disp_zero_n", {31'h0, dz4n}, {31'h0, (v == 32'h0)});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q4.size() == 0 && q4n.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain4", q4.size(), 0);
    chk("drain4n", q4n.size(), 0);
  endtask

  // Slot monitor for the REFRESH_DIV=4 displays
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (an4 != prev4 && an4 != 8'hFF) begin
      if (prev4 != 8'hFF) chk("slot_gap", cyc - last4, 4);
      if (q4.size() == 0) chk("q4_extra", {24'h0, an4}, 32'hFF);
      else begin
        chk("an4", {24'h0, an4}, {24'h0, q4[0].an});
        chk("led4", {25'h0, led4}, {25'h0, q4[0].led});
        void'(q4.pop_front());
      end
    end
    if (an4 != prev4) last4 <= cyc;
    prev4 <= an4;
  end

  always @(negedge clk) begin
    if (an4n != prev4n && an4n != 8'hFF) begin
      if (q4n.size() == 0) chk("q4n_extra", {24'h0, an4n}, 32'hFF);
      else begin
        chk("an4n", {24'h0, an4n}, {24'h0, q4n[0].an});
        chk("led4n", {25'h0, led4n}, {25'h0, q4n[0].led});
        void'(q4n.pop_front());
      end
    end
    prev4n <= an4n;
  end

  // REFRESH_DIV=1: the anode must move every cycle and wrap 7F -> FE
  always @(negedge clk) begin
    if (!rst && an1 != 8'hFF)
      chk("rot1", {24'h0, an1}, (prev1 == 8'hFF) ? 32'hFE : {24'h0, prev1[6:0], prev1[7]});
    prev1 <= an1;
  end

  initial begin
    rst = 1'b1; load = 1'b0; value_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", {24'h0, an4}, 32'hFF);
    chk("rst_led", {25'h0, led4}, 32'h7F);
    chk("rst_dz", {31'h0, dz4}, 32'h1);

    // full scan, every digit non-zero
    push_scan(32'h1234ABCD, 0, 7);
    start(32'h1234ABCD);
    drain(60);

    // leading zeros blanked on u4, shown on u4n
    push_scan(32'h000000A5, 0, 7);
    start(32'h000000A5);
    drain(60);

    // zero value: single "0" on digit 0
    push_scan(32'h0, 0, 7);
    start(32'h0);
    drain(60);

    // load lands on the tick edge that enters digit 2
    push_scan(32'h1234ABCD, 0, 2);
    push_scan(32'hFFFFFFFF, 3, 7);
    start(32'h1234ABCD);
    repeat (10) @(posedge clk);
    #1;
    load = 1'b1; value_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    load = 1'b0;
    chk("dz_ff", {31'h0, dz4}, 32'h0);
    drain(60);

    // reset while digit 5 is active
    push_scan(32'h1234ABCD, 0, 5);
    start(32'h1234ABCD);
    repeat (24) @(posedge clk);
    #1;
    chk("pre_rst_an", {24'h0, an4}, 32'hDF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_an", {24'h0, an4}, 32'hFF);
    chk("mid_rst_led", {25'h0, led4}, 32'h7F);
    chk("mid_rst_dz", {31'h0, dz4}, 32'h1);
    chk("mid_rst_q", q4.size(), 0);
    push_scan(32'h0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_an", {24'h0, an4}, 32'hFE);
    chk("post_rst_led", {25'h0, led4}, 32'h01);
    drain(20);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
